// File: rtl/register_file_bank_pkg.sv
// Shared sizing and types for the integer register file.
// Defaults describe the RV32I architectural register set.
package register_file_bank_pkg;

  localparam int WORD_SIZE = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_bank_reg_cell.sv
// One architectural register: sync reset, active-low load.
// Reset wins over the load enable.
module reg_cell #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wen_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (!wen_ni) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/register_file_bank.sv
// Integer register file: per-register write lanes, full parallel
// view of the contents and two combinational rs read ports.
module register_file_bank #(
  parameter int WORD_SIZE     = register_file_bank_pkg::WORD_SIZE,
  parameter int NUM_REGS      = register_file_bank_pkg::NUM_REGS,
  parameter int HARDWIRE_ZERO = 1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wenableL [NUM_REGS],
  input  logic [WORD_SIZE-1:0] data_w   [NUM_REGS],
  output logic [WORD_SIZE-1:0] data_r   [NUM_REGS],
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic [WORD_SIZE-1:0] rs1_data,
  output logic [WORD_SIZE-1:0] rs2_data
);

  import register_file_bank_pkg::*;

  for (genvar j = 0; j < NUM_REGS; j++) begin : g_reg
    if (j == 0 && HARDWIRE_ZERO != 0) begin : g_zero
      // x0: no storage; its write lane is deliberately dropped
      logic unused_x0;
      assign unused_x0 = ^{wenableL[0], data_w[0]};
      assign data_r[0] = '0;
    end else begin : g_cell
      reg_cell #(
        .W (WORD_SIZE)
      ) u_cell (
        .clk_i  (clk),
        .rst_i  (rst),
        .wen_ni (wenableL[j]),
        .d_i    (data_w[j]),
        .q_o    (data_r[j])
      );
    end
  end

  always_comb begin
    rs1_data = data_r[rs1_addr];
    rs2_data = data_r[rs2_addr];
  end

endmodule

// File: tb/tb_register_file_bank.sv
// Randomized and directed checks of register_file_bank against
// an array model of the architectural register state.
module tb_register_file_bank;
  import register_file_bank_pkg::*;

  localparam int N = NUM_REGS;

  logic     clk;
  logic     rst;
  logic     wenableL [N];
  word_t    data_w   [N];
  word_t    data_r   [N];
  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  word_t    rs1_data;
  word_t    rs2_data;

  register_file_bank dut (
    .clk      (clk),
    .rst      (rst),
    .wenableL (wenableL),
    .data_w   (data_w),
    .data_r   (data_r),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    check_en = 1'b0;
  word_t model [N];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Model: state after each edge from the rules, x0 stays zero
  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) model[j] = '0;
    end else begin
      for (int j = 1; j < N; j++)
        if (wenableL[j] == 1'b0) model[j] = data_w[j];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int j = 0; j < N; j++)
        check($sformatf("data_r[%0d]", j), data_r[j], model[j]);
      check("rs1_data", rs1_data, model[rs1_addr]);
      check("rs2_data", rs2_data, model[rs2_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_enables();
    for (int j = 0; j < N; j++) wenableL[j] = 1'b1;
  endtask

  task automatic bulk_write();
    for (int j = 0; j < N; j++) begin
      wenableL[j] = 1'b0;
      data_w[j]   = 32'h1000_0000 + j;
    end
    step();
    idle_enables();
  endtask

  initial begin
    for (int j = 0; j < N; j++) model[j] = '0;
    rst      = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    for (int j = 0; j < N; j++) begin
      wenableL[j] = 1'b0;
      data_w[j]   = 32'hFFFF_FFFF;
    end
    step();
    rst = 1'b0;
    idle_enables();
    check_en = 1'b1;
    for (int j = 0; j < N; j++)
      check($sformatf("reset r%0d", j), data_r[j], 32'h0);

    bulk_write();
    check("bulk r0", data_r[0], 32'h0);
    check("bulk r1", data_r[1], 32'h1000_0001);
    check("bulk r31", data_r[31], 32'h1000_001F);
    repeat (10) step();
    check("hold r1", data_r[1], 32'h1000_0001);
    check("hold r17", data_r[17], 32'h1000_0011);

    for (int j = 0; j < N; j++) data_w[j] = 32'h1234_5678;
    wenableL[5] = 1'b0;
    data_w[5]   = 32'hDEAD_BEEF;
    step();
    idle_enables();
    check("sel r5", data_r[5], 32'hDEAD_BEEF);
    check("sel r4", data_r[4], 32'h1000_0004);
    check("sel r6", data_r[6], 32'h1000_0006);

    wenableL[0] = 1'b0;
    data_w[0]   = 32'hCAFE_F00D;
    rs1_addr    = 5'd0;
    step();
    idle_enables();
    #1;
    check("x0 data_r", data_r[0], 32'h0);
    check("x0 rs1", rs1_data, 32'h0);

    wenableL[7] = 1'b0;
    data_w[7]   = 32'hA5A5_A5A5;
    step();
    data_w[7] = 32'h5A5A_5A5A;
    rs1_addr  = 5'd7;
    rs2_addr  = 5'd7;
    #1;
    check("nobyp rs1", rs1_data, 32'hA5A5_A5A5);
    check("nobyp rs2", rs2_data, 32'hA5A5_A5A5);
    step();
    idle_enables();
    #1;
    check("after rs1", rs1_data, 32'h5A5A_5A5A);
    check("after rs2", rs2_data, 32'h5A5A_5A5A);

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(39) == 0);
      for (int j = 0; j < N; j++) begin
        wenableL[j] = ($urandom_range(3) != 0);
        data_w[j]   = $urandom;
      end
      rs1_addr = reg_idx_t'($urandom_range(N - 1));
      rs2_addr = reg_idx_t'($urandom_range(N - 1));
      step();
    end
    rst = 1'b0;
    idle_enables();

    bulk_write();
    rst         = 1'b1;
    wenableL[3] = 1'b0;
    data_w[3]   = 32'h1;
    step();
    rst = 1'b0;
    idle_enables();
    check("midrst r3", data_r[3], 32'h0);
    check("midrst r9", data_r[9], 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_bank.md
Name: register_file_bank

Overview:
- Architectural integer register file for the miscv32 core: NUM_REGS registers, each WORD_SIZE bits wide.
- Every register has its own write-data lane and its own active-low write enable, so any subset can be written in one cycle.
- All register contents are presented in parallel on data_r.
- Two addressed combinational read ports (rs1/rs2) serve the decode stage.

Parameters:
- WORD_SIZE, 32, bit width of each register.
- NUM_REGS, 32, number of registers. Must be a power of two, at least 2.
- HARDWIRE_ZERO, 1, when 1 register 0 always reads zero and ignores writes (RISC-V x0).

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge clk.
- rst  in  1  synchronous active-high reset.
- wenableL  in  NUM_REGS x 1 (unpacked array)  per-register write enable, active low (0 = write).
- data_w  in  NUM_REGS x WORD_SIZE (unpacked array)  per-register write data.
- data_r  out  NUM_REGS x WORD_SIZE (unpacked array)  current contents of every register.
- rs1_addr  in  $clog2(NUM_REGS)  read port 1 index.
- rs2_addr  in  $clog2(NUM_REGS)  read port 2 index.
- rs1_data  out  WORD_SIZE  contents of register rs1_addr.
- rs2_data  out  WORD_SIZE  contents of register rs2_addr.

Behaviour:
- Storage: NUM_REGS flops of WORD_SIZE bits. No other state.
- Reset: on a posedge clk with rst=1, all registers become 0. Reset has priority over every write enable in that cycle.
- Write: on a posedge clk with rst=0, each register j with wenableL[j]==0 loads data_w[j]. Each register j with wenableL[j]==1 holds its value.
- Writes to different registers are fully independent; all enabled registers update in the same edge.
- Register 0 with HARDWIRE_ZERO=1: never written, and reads 0 on data_r[0] and on both rs ports regardless of wenableL[0] or data_w[0].
- data_r[j]: driven directly from register j, no combinational path from data_w. A write becomes visible on data_r one cycle later, immediately after the capturing edge.
- rs1_data / rs2_data: combinational mux of the stored registers. No write-to-read bypass: reading a register in the same cycle it is written returns the old value.
- Both read ports may address the same register simultaneously.
- X/undriven wenableL bits are not defined behaviour. The bench drives all enables to a known value.
- After reset is released, contents persist indefinitely while all wenableL bits are 1.
- Reset asserted mid-operation: the next posedge zeroes everything, and pending writes in that cycle are dropped.

Decomposition:
- Shared package (e.g. core_pkg) holds:
  - WORD_SIZE = 32 and NUM_REGS = 32 as localparams.
  - word_t = logic [WORD_SIZE-1:0].
  - reg_idx_t = logic [$clog2(NUM_REGS)-1:0].
- The module imports the package and uses these as parameter defaults.
- Natural sub-module: reg_cell, a single WORD_SIZE register with sync reset and active-low enable. Instantiate it in a generate loop for j = 1..NUM_REGS-1; register 0 is a generate-if on HARDWIRE_ZERO.
- Read ports are plain always_comb muxes in the top.

Test Plan:
- Reset: drive all data_w=32'hFFFF_FFFF and wenableL all 0, assert rst for 1 cycle -> every data_r[j]=0 after the edge. Reset beats writes.
- Bulk write: all wenableL=0 with data_w[j]=32'h1000_0000+j for 1 cycle, then all enables 1 -> data_r[j]=32'h1000_0000+j for j>=1, data_r[0]=0, values held for 10 further cycles.
- Selective write: only wenableL[5]=0 with data_w[5]=32'hDEAD_BEEF and all other data_w=32'h1234_5678 -> only data_r[5] changes; the others are unchanged.
- x0 hardwiring: wenableL[0]=0, data_w[0]=32'hCAFE_F00D -> data_r[0]=0; rs1_addr=0 gives rs1_data=0.
- Read ports, no bypass: r7 holds 32'hA5A5_A5A5; in the same cycle write r7=32'h5A5A_5A5A with rs1_addr=rs2_addr=7:
  - before the edge, both ports read 32'hA5A5_A5A5;
  - after the edge, both read 32'h5A5A_5A5A.
- Mid-run reset: after the bulk write, assert rst together with wenableL[3]=0, data_w[3]=32'h1 -> all registers read 0, including r3.
